// File: rtl/pkt_con_arb.sv
// pkt_con_arb: merges X_DIR+Y_DIR incoming packet links onto one registered node-input port.
// Arbitration uses two QoS classes, round-robin within each class, and bounds how long the
// low class can be starved while high-class traffic keeps arriving.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_vld_i/in_rdy_o/in_qos_i       per-channel valid, one-hot-or-zero ready, class (1=hi)
//   in_type_i/in_src_i/in_tgt_i/
//   in_data_i                        packed per-channel fields, channel i at [i*W +: W]
//   out_vld_o/out_rdy_i              registered output handshake
//   out_qos_o/out_type_o/out_src_o/
//   out_tgt_o/out_data_o/out_ch_o    held packet fields and the channel it arrived on
module pkt_con_arb #(
    parameter int X_DIR   = 7,
    parameter int Y_DIR   = 7,
    parameter int TYPE_W  = 4,
    parameter int ID_W    = 8,
    parameter int FLIT_W  = 32,
    parameter int AGE_MAX = 4,
    localparam int N      = X_DIR + Y_DIR,
    localparam int CH_W   = (N > 1) ? $clog2(N) : 1,
    localparam int AGE_W  = $clog2(AGE_MAX + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_vld_i,
    output logic [N-1:0]        in_rdy_o,
    input  logic [N-1:0]        in_qos_i,
    input  logic [N*TYPE_W-1:0] in_type_i,
    input  logic [N*ID_W-1:0]   in_src_i,
    input  logic [N*ID_W-1:0]   in_tgt_i,
    input  logic [N*FLIT_W-1:0] in_data_i,
    output logic                out_vld_o,
    input  logic                out_rdy_i,
    output logic                out_qos_o,
    output logic [TYPE_W-1:0]   out_type_o,
    output logic [ID_W-1:0]     out_src_o,
    output logic [ID_W-1:0]     out_tgt_o,
    output logic [FLIT_W-1:0]   out_data_o,
    output logic [CH_W-1:0]     out_ch_o
);
    logic [CH_W-1:0]  hi_ptr_q, lo_ptr_q, hi_win, lo_win, win;
    logic [AGE_W-1:0] age_q;
    logic [N-1:0]     hi_req, lo_req;
    logic             load, pick_lo, xfer;

    assign hi_req  = in_vld_i & in_qos_i;
    assign lo_req  = in_vld_i & ~in_qos_i;
    assign load    = !out_vld_o || out_rdy_i;
    // Low class wins when it is alone or when the high class has used up its age budget.
    assign pick_lo = (lo_req != '0) && ((hi_req == '0) || (age_q == AGE_W'(AGE_MAX)));
    assign win     = pick_lo ? lo_win : hi_win;
    // Gated with rst_n so no sender sees a grant while the port is held in reset.
    assign xfer    = load && (in_vld_i != '0) && rst_n;
    assign in_rdy_o = xfer ? (N'(1) << win) : '0;

    // Round-robin search: scanning from the far end lets the nearest requester after ptr win.
    always_comb begin
        int hi_i, lo_i;
        hi_win = '0;
        lo_win = '0;
        hi_i   = 0;
        lo_i   = 0;
        for (int k = N; k >= 1; k--) begin
            hi_i = (int'(hi_ptr_q) + k) % N;
            lo_i = (int'(lo_ptr_q) + k) % N;
            if (hi_req[hi_i]) hi_win = CH_W'(hi_i);
            if (lo_req[lo_i]) lo_win = CH_W'(lo_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_o  <= 1'b0;
            out_qos_o  <= 1'b0;
            out_type_o <= '0;
            out_src_o  <= '0;
            out_tgt_o  <= '0;
            out_data_o <= '0;
            out_ch_o   <= '0;
            hi_ptr_q   <= CH_W'(N - 1);
            lo_ptr_q   <= CH_W'(N - 1);
            age_q      <= '0;
        end else begin
            if (xfer) begin
                out_vld_o  <= 1'b1;
                out_qos_o  <= !pick_lo;
                out_type_o <= in_type_i[win*TYPE_W +: TYPE_W];
                out_src_o  <= in_src_i[win*ID_W +: ID_W];
                out_tgt_o  <= in_tgt_i[win*ID_W +: ID_W];
                out_data_o <= in_data_i[win*FLIT_W +: FLIT_W];
                out_ch_o   <= win;
                if (pick_lo) lo_ptr_q <= win;
                else hi_ptr_q <= win;
            end else if (out_rdy_i) begin
                out_vld_o <= 1'b0;
            end
            if (lo_req == '0) age_q <= '0;
            else if (xfer) age_q <= pick_lo ? '0 : (age_q == AGE_W'(AGE_MAX) ? age_q : age_q + 1'b1);
        end
    end
endmodule

// File: tb/tb_pkt_con_arb.sv
// tb_pkt_con_arb: directed scoreboard bench for pkt_con_arb (7+7 channels, AGE_MAX=4).
module tb_pkt_con_arb;
    localparam int N = 14, TW = 4, IW = 8, FW = 32, CW = 4;

    typedef struct packed {
        logic [CW-1:0] ch;
        logic          qos;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    in_vld, in_rdy, in_qos;
    logic [N*TW-1:0] in_type;
    logic [N*IW-1:0] in_src, in_tgt;
    logic [N*FW-1:0] in_data;
    logic            out_vld, out_rdy, out_qos;
    logic [TW-1:0]   out_type;
    logic [IW-1:0]   out_src, out_tgt;
    logic [FW-1:0]   out_data;
    logic [CW-1:0]   out_ch;
    exp_t            q[$];
    int              vecs = 0;
    int              errs = 0;

    always #5 clk = ~clk;

    pkt_con_arb #(.X_DIR(7), .Y_DIR(7), .TYPE_W(TW), .ID_W(IW), .FLIT_W(FW), .AGE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld_i(in_vld), .in_rdy_o(in_rdy), .in_qos_i(in_qos),
        .in_type_i(in_type), .in_src_i(in_src), .in_tgt_i(in_tgt), .in_data_i(in_data),
        .out_vld_o(out_vld), .out_rdy_i(out_rdy), .out_qos_o(out_qos),
        .out_type_o(out_type), .out_src_o(out_src), .out_tgt_o(out_tgt),
        .out_data_o(out_data), .out_ch_o(out_ch)
    );

    // Each sender carries fields derived from its own channel index.
    function automatic logic [TW-1:0] f_type(int c); return TW'(c); endfunction
    function automatic logic [IW-1:0] f_src(int c);  return IW'(c) + 8'h10; endfunction
    function automatic logic [IW-1:0] f_tgt(int c);  return IW'(c) ^ 8'h5A; endfunction
    function automatic logic [FW-1:0] f_data(int c); return {16'hC0DE, IW'(c), ~IW'(c)}; endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(int c, logic qs);
        exp_t e;
        e.ch  = CW'(c);
        e.qos = qs;
        q.push_back(e);
    endtask

    task automatic run(logic [N-1:0] v, logic [N-1:0] qs, int n);
        in_vld = v;
        in_qos = qs;
        repeat (n) @(posedge clk);
        #1 in_vld = '0;
    endtask

    task automatic drain(string name);
        repeat (2) @(negedge clk);
        check(name, 64'(q.size()), 64'd0);
        check({name, "_idle"}, 64'(out_vld), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output beat is matched against the next expected packet.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_vld && out_rdy) begin
            if (q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL unexpected_out: got ch %0d expected no packet", out_ch);
            end else begin
                e = q.pop_front();
                check("out_ch", 64'(out_ch), 64'(e.ch));
                check("out_qos", 64'(out_qos), 64'(e.qos));
                check("out_type", 64'(out_type), 64'(f_type(int'(e.ch))));
                check("out_src", 64'(out_src), 64'(f_src(int'(e.ch))));
                check("out_tgt", 64'(out_tgt), 64'(f_tgt(int'(e.ch))));
                check("out_data", 64'(out_data), 64'(f_data(int'(e.ch))));
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            in_type[i*TW +: TW] = f_type(i);
            in_src[i*IW +: IW]  = f_src(i);
            in_tgt[i*IW +: IW]  = f_tgt(i);
            in_data[i*FW +: FW] = f_data(i);
        end
        in_vld  = '1;
        in_qos  = '0;
        out_rdy = 1'b1;

        // 1: reset with all channels requesting, then the first grant is ch0
        repeat (2) @(negedge clk);
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_in_rdy", 64'(in_rdy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        push(0, 1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 in_vld = '0;
        drain("t1_drain");

        // 2: low-class round robin over all channels, lo_ptr now at 0
        for (int c = 1; c < N; c++) push(c, 1'b0);
        push(0, 1'b0);
        push(1, 1'b0);
        run(14'h3FFF, '0, 15);
        drain("t2_drain");

        // 3: ch3 high class against ch5/ch9 low class, age limit 4
        for (int r = 0; r < 2; r++) begin
            repeat (4) push(3, 1'b1);
            push(r == 0 ? 5 : 9, 1'b0);
        end
        run(14'h0228, 14'h0008, 10);
        drain("t3_drain");

        // 4: backpressure after one capture, then release without a bubble
        out_rdy = 1'b0;
        push(2, 1'b0);
        push(4, 1'b0);
        in_vld = 14'h0014;
        in_qos = '0;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_hold_vld", 64'(out_vld), 64'd1);
            check("t4_hold_ch", 64'(out_ch), 64'd2);
            check("t4_hold_data", 64'(out_data), 64'(f_data(2)));
            check("t4_in_rdy", 64'(in_rdy), 64'd0);
        end
        @(posedge clk);
        #1 out_rdy = 1'b1;
        @(posedge clk);
        #1 in_vld = '0;
        @(negedge clk);
        check("t4_no_bubble", 64'(out_vld), 64'd1);
        drain("t4_drain");

        // 5: one x link and one y link alternate
        push(6, 1'b0);
        push(7, 1'b0);
        push(6, 1'b0);
        push(7, 1'b0);
        run(14'h00C0, '0, 4);
        drain("t5_drain");

        // 6: async reset while a packet is held, pointers restart at ch0
        push(8, 1'b0);
        in_vld = '1;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_vld", 64'(out_vld), 64'd0);
        check("t6_rst_rdy", 64'(in_rdy), 64'd0);
        check("t6_rst_ch", 64'(out_ch), 64'd0);
        push(0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 in_vld = '0;
        drain("t6_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
